imem_fetch_queue: RTL and testbench
===================================

// Module: imem_fetch_queue
// PURPOSE
//  Parametrised successor to the combinational instruction memory: synchronous-read
//  instruction RAM plus a prefetch queue of decoded-ready words. Streams one instruction
//  per cycle to the decode stage under a VALID/STALL handshake, and flushes on REDIRECT.
//  Sits between the PC/branch logic and decode; decode fields come from the queue head.
// PARAMETERS
//  INITFILE   "Test2.mif"  RAM init file (ram_init_file attribute)
//  DBITS      32           instruction / data width
//  ADDRBITS   13           byte-address width of PCs
//  WORDBITS   2            byte-offset bits dropped to form word index
//  MEMWORDS   2048         RAM depth in words
//  OPCODEBITS 5            OP1/OP2 width;  REGNOBITS 5  register-number width
//  IMMBITS    17           raw immediate width, sign-extended to DBITS
//  QDEPTH     4            prefetch queue entries (power of 2, >=2)
//  STARTPC    0            byte PC loaded on reset
// PORTS
//  CLK      in  1           clock, rising edge
//  RESET    in  1           synchronous, active-high
//  STALL    in  1           decode not ready; head held while high
//  REDIRECT in  1           branch/jump taken: flush and refetch
//  REDIRPC  in  ADDRBITS    byte target PC, sampled when REDIRECT=1
//  VALID    out 1           head entry valid
//  PCOUT    out ADDRBITS    byte PC of head instruction
//  NEXTPC   out ADDRBITS    PCOUT+4, wraps mod 2^ADDRBITS
//  OP1      out OPCODEBITS  inst[31:27];  RX inst[26:22]; RY inst[21:17]; RZ inst[16:12]
//  RX/RY/RZ out REGNOBITS   register fields of head
//  OP2      out OPCODEBITS  inst[OPCODEBITS-1:0]
//  IMM      out DBITS       sign-extended inst[IMMBITS-1:0]
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. On RESET: fetch PC<=STARTPC, queue empty,
//    in-flight read invalid, VALID=0. PCOUT/NEXTPC/fields/IMM read 0 while VALID=0.
//  - Pipeline: issue (fetch PC drives RAM addr = PC[ADDRBITS-1:WORDBITS]) -> registered
//    RAM output + in-flight valid bit (IFV) -> queue push on the following edge.
//  - Latency: VALID rises after the 2nd rising edge with RESET low; likewise 2 edges
//    after a REDIRECT edge. Steady state 1 instr/cycle while STALL=0.
//  - Consume: pop = VALID & ~STALL at an edge. Head fields stable while STALL=1.
//  - Issue rule: issue = (count + IFV - pop) < QDEPTH; on issue fetch PC <= PC+4 (wraps).
//    Guarantees no overflow; a push never finds the queue full.
//  - Simultaneous push+pop: count unchanged; push into empty queue with pop impossible.
//  - REDIRECT (priority over pop/push/issue): queue emptied, IFV<=0 (read in flight
//    discarded), fetch PC <= REDIRPC; VALID=0 next cycle. REDIRECT while STALL=1 same.
//  - RESET overrides REDIRECT. Word index beyond MEMWORDS: undefined data, no error.
//  - REDIRPC low WORDBITS bits ignored for addressing, kept in PCOUT.
// STRUCTURE
//  - imem_defs.vh: field bit positions (OP1 31:27, RX 26:22, RY 21:17, RZ 16:12),
//    width defaults, PC increment constant 4.
//  - Sub-module imem_fifo (sync FIFO, width ADDRBITS+DBITS, depth QDEPTH, flush input,
//    count output); existing SignExtend reused for IMM. Top holds PC, RAM, IFV, issue logic.
// TESTING  (MIF: word i = 32'h0800_0000*(i%32) | i; i.e. OP1=i%32, low bits=i)
//  1 Reset release, STALL=0 -> VALID=1 after 2nd edge, PCOUT 0,4,8,.. one per cycle, IMM=0,1,2..
//  2 STALL=1 from cycle 3 for 10 cycles -> head holds PCOUT=4, no more than QDEPTH
//    issues, then resume with no gap/duplicate: 4,8,12,16,20.
//  3 REDIRECT REDIRPC=0x100 mid-stream -> VALID=0 next cycle, then PCOUT 0x100,0x104;
//    stale words (e.g. PC 0x10) never appear.
//  4 REDIRECT with STALL=1 and queue full -> same as 3; count=0 after edge.
//  5 REDIRPC=0x1FFC (top word) -> PCOUT 0x1FFC then 0x0000, NEXTPC wraps to 0.
//  6 RESET asserted mid-stream with REDIRECT=1 -> VALID=0, restart at STARTPC.

Source files
------------

// File: rtl/imem_fetch_queue_pkg.sv
// imem_fetch_queue_pkg: shared widths, field positions and PC step for the fetch queue
package imem_fetch_queue_pkg;
  localparam int DBITS_DEF      = 32;
  localparam int ADDRBITS_DEF   = 13;
  localparam int WORDBITS_DEF   = 2;
  localparam int MEMWORDS_DEF   = 2048;
  localparam int OPCODEBITS_DEF = 5;
  localparam int REGNOBITS_DEF  = 5;
  localparam int IMMBITS_DEF    = 17;
  localparam int QDEPTH_DEF     = 4;
  localparam int IDXBITS_DEF    = ADDRBITS_DEF - WORDBITS_DEF;
  localparam int OP1_LSB        = 27;
  localparam int RX_LSB         = 22;
  localparam int RY_LSB         = 17;
  localparam int RZ_LSB         = 12;
  localparam int PC_INC         = 4;
endpackage

// File: rtl/imem_fetch_queue_if.sv
// imem_fetch_queue_if: decode-side handshake, redirect and program-load bus of the fetch queue
interface imem_fetch_queue_if
  import imem_fetch_queue_pkg::*;
#(
  parameter int ADDRBITS   = ADDRBITS_DEF,
  parameter int DBITS      = DBITS_DEF,
  parameter int OPCODEBITS = OPCODEBITS_DEF,
  parameter int REGNOBITS  = REGNOBITS_DEF,
  parameter int IDXBITS    = IDXBITS_DEF
);
  logic                  stall_i;
  logic                  redirect_i;
  logic [ADDRBITS-1:0]   redir_pc_i;
  logic                  ld_en_i;
  logic [IDXBITS-1:0]    ld_addr_i;
  logic [DBITS-1:0]      ld_data_i;
  logic                  valid_o;
  logic [ADDRBITS-1:0]   pc_o;
  logic [ADDRBITS-1:0]   next_pc_o;
  logic [OPCODEBITS-1:0] op1_o;
  logic [REGNOBITS-1:0]  rx_o;
  logic [REGNOBITS-1:0]  ry_o;
  logic [REGNOBITS-1:0]  rz_o;
  logic [OPCODEBITS-1:0] op2_o;
  logic [DBITS-1:0]      imm_o;
  modport master (
    output stall_i, redirect_i, redir_pc_i, ld_en_i, ld_addr_i, ld_data_i,
    input  valid_o, pc_o, next_pc_o, op1_o, rx_o, ry_o, rz_o, op2_o, imm_o
  );
  modport slave (
    input  stall_i, redirect_i, redir_pc_i, ld_en_i, ld_addr_i, ld_data_i,
    output valid_o, pc_o, next_pc_o, op1_o, rx_o, ry_o, rz_o, op2_o, imm_o
  );
endinterface

// File: rtl/imem_fetch_queue_fifo.sv
// imem_fetch_queue_fifo: synchronous FIFO with flush and occupancy count, head visible combinationally
module imem_fetch_queue_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4,
  localparam int PBITS = $clog2(DEPTH),
  localparam int CBITS = PBITS + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CBITS-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PBITS-1:0] rd_q, wr_q;
  logic [CBITS-1:0] cnt_q;
  // pointers and count; flush empties the queue like reset
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PBITS'(1);
      if (pop_i) rd_q <= rd_q + PBITS'(1);
      cnt_q <= cnt_q + CBITS'(push_i) - CBITS'(pop_i);
    end
  end
  // storage; stale contents are harmless once pointers are reset
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: synchronous instruction RAM feeding a prefetch queue that streams decoded fields to decode
module imem_fetch_queue
  import imem_fetch_queue_pkg::*;
#(
  parameter int DBITS      = DBITS_DEF,
  parameter int ADDRBITS   = ADDRBITS_DEF,
  parameter int WORDBITS   = WORDBITS_DEF,
  parameter int MEMWORDS   = MEMWORDS_DEF,
  parameter int OPCODEBITS = OPCODEBITS_DEF,
  parameter int REGNOBITS  = REGNOBITS_DEF,
  parameter int IMMBITS    = IMMBITS_DEF,
  parameter int QDEPTH     = QDEPTH_DEF,
  parameter logic [ADDRBITS-1:0] STARTPC = '0
) (
  input logic clk_i,
  input logic rst_i,
  imem_fetch_queue_if.slave bus
);
  localparam int CBITS = $clog2(QDEPTH) + 1;
  logic [DBITS-1:0] mem_q [MEMWORDS];
  logic [ADDRBITS-1:0] pc_q, pc_d, rpc_q, head_pc;
  logic [DBITS-1:0] rdata_q, inst;
  logic ifv_q, ifv_d, issue, pop, push, valid;
  logic [CBITS-1:0] count;
  assign valid = count != '0;
  assign pop   = valid & ~bus.stall_i;
  assign push  = ifv_q & ~bus.redirect_i;
  assign issue = (int'(count) + int'(ifv_q) - int'(pop)) < QDEPTH;
  // next fetch PC and in-flight flag; redirect discards the read in flight
  always_comb begin
    pc_d  = bus.redirect_i ? bus.redir_pc_i : issue ? pc_q + ADDRBITS'(PC_INC) : pc_q;
    ifv_d = ~bus.redirect_i & issue;
  end
  // fetch state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= STARTPC;
      ifv_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ifv_q <= ifv_d;
    end
  end
  // RAM: program load write port and registered read tagged with its PC
  always_ff @(posedge clk_i) begin
    if (bus.ld_en_i) mem_q[bus.ld_addr_i] <= bus.ld_data_i;
    rdata_q <= mem_q[pc_q[ADDRBITS-1:WORDBITS]];
    rpc_q   <= pc_q;
  end
  imem_fetch_queue_fifo #(.WIDTH(ADDRBITS + DBITS), .DEPTH(QDEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (bus.redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({rpc_q, rdata_q}),
    .dout_o  ({head_pc, inst}),
    .count_o (count)
  );
  assign bus.valid_o   = valid;
  assign bus.pc_o      = valid ? head_pc : '0;
  assign bus.next_pc_o = valid ? head_pc + ADDRBITS'(PC_INC) : '0;
  assign bus.op1_o     = valid ? inst[OP1_LSB +: OPCODEBITS] : '0;
  assign bus.rx_o      = valid ? inst[RX_LSB +: REGNOBITS] : '0;
  assign bus.ry_o      = valid ? inst[RY_LSB +: REGNOBITS] : '0;
  assign bus.rz_o      = valid ? inst[RZ_LSB +: REGNOBITS] : '0;
  assign bus.op2_o     = valid ? inst[OPCODEBITS-1:0] : '0;
  assign bus.imm_o     = valid ? {{(DBITS-IMMBITS){inst[IMMBITS-1]}}, inst[IMMBITS-1:0]} : '0;
endmodule

// File: tb/tb_imem_fetch_queue.sv
// tb_imem_fetch_queue: directed scoreboard bench for the instruction fetch queue
module tb_imem_fetch_queue;
  import imem_fetch_queue_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [2048];
  logic [12:0] sb [$];
  imem_fetch_queue_if bus ();
  imem_fetch_queue dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [16:0] v);
    return {{15{v[16]}}, v};
  endfunction

  task automatic expect_from(input logic [12:0] start);
    logic [12:0] p;
    p = start;
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      sb.push_back(p);
      p = p + 13'd4;
    end
  endtask

  task automatic check_out();
    logic [31:0] w;
    logic [12:0] e;
    if (bus.valid_o && !bus.redirect_i && !rst) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty observed=pc %h expected=no output", bus.pc_o);
      end
      if (sb.size() != 0) begin
        e = sb[0];
        w = model[e[12:2]];
        chk("head_pc", 64'(bus.pc_o), 64'(e));
        if (!bus.stall_i) begin
          void'(sb.pop_front());
          chk("next_pc", 64'(bus.next_pc_o), 64'(13'(e + 13'd4)));
          chk("fields", 64'({bus.op1_o, bus.rx_o, bus.ry_o, bus.rz_o, bus.op2_o}),
              64'({w[31:27], w[26:22], w[21:17], w[16:12], w[4:0]}));
          chk("imm", 64'(bus.imm_o), 64'(sext(w[16:0])));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redir_pc_i = '0;
    bus.ld_en_i = 1'b0;
    bus.ld_addr_i = '0;
    bus.ld_data_i = '0;
    for (int i = 0; i < 2048; i++) model[i] = (32'h0800_0000 * 32'(i % 32)) | 32'(i);
    model[65] = 32'h8765_4321;
    @(posedge clk);
    #1;
    bus.ld_en_i = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      bus.ld_addr_i = 11'(i);
      bus.ld_data_i = model[i];
      @(posedge clk);
      #1;
    end
    bus.ld_en_i = 1'b0;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_pc", 64'(bus.pc_o), 64'd0);
    chk("rst_next_pc", 64'(bus.next_pc_o), 64'd0);
    chk("rst_imm", 64'(bus.imm_o), 64'd0);
    rst = 1'b0;
    expect_from(13'h0);
    tick();
    chk("lat1_valid", 64'(bus.valid_o), 64'd0);
    tick();
    chk("lat2_valid", 64'(bus.valid_o), 64'd1);
    chk("lat2_pc", 64'(bus.pc_o), 64'h0);
    repeat (6) tick();
    bus.stall_i = 1'b1;
    repeat (10) tick();
    chk("stall_count", 64'(dut.count), 64'd4);
    chk("stall_ifv", 64'(dut.ifv_q), 64'd0);
    bus.stall_i = 1'b0;
    repeat (6) tick();
    bus.redirect_i = 1'b1;
    bus.redir_pc_i = 13'h100;
    tick();
    bus.redirect_i = 1'b0;
    expect_from(13'h100);
    chk("redir_valid0", 64'(bus.valid_o), 64'd0);
    tick();
    chk("redir_valid1", 64'(bus.valid_o), 64'd0);
    tick();
    chk("redir_valid2", 64'(bus.valid_o), 64'd1);
    chk("redir_pc", 64'(bus.pc_o), 64'h100);
    repeat (5) tick();
    bus.stall_i = 1'b1;
    repeat (8) tick();
    chk("full_count", 64'(dut.count), 64'd4);
    bus.redirect_i = 1'b1;
    bus.redir_pc_i = 13'h200;
    tick();
    bus.redirect_i = 1'b0;
    expect_from(13'h200);
    chk("stall_redir_valid", 64'(bus.valid_o), 64'd0);
    chk("stall_redir_count", 64'(dut.count), 64'd0);
    bus.stall_i = 1'b0;
    tick();
    chk("stall_redir_valid1", 64'(bus.valid_o), 64'd0);
    tick();
    chk("stall_redir_pc", 64'(bus.pc_o), 64'h200);
    repeat (4) tick();
    bus.redirect_i = 1'b1;
    bus.redir_pc_i = 13'h1FFC;
    tick();
    bus.redirect_i = 1'b0;
    expect_from(13'h1FFC);
    tick();
    tick();
    chk("wrap_pc", 64'(bus.pc_o), 64'h1FFC);
    chk("wrap_next_pc", 64'(bus.next_pc_o), 64'h0);
    repeat (4) tick();
    rst = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redir_pc_i = 13'h300;
    tick();
    chk("rst_redir_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_redir_fetch_pc", 64'(dut.pc_q), 64'h0);
    rst = 1'b0;
    bus.redirect_i = 1'b0;
    expect_from(13'h0);
    tick();
    tick();
    chk("restart_valid", 64'(bus.valid_o), 64'd1);
    chk("restart_pc", 64'(bus.pc_o), 64'h0);
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
